// File: rtl/lsu_pkg.sv
// Shared constants for the APB load/store unit: funct3 access codes, error causes, FSM encoding.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_SLV     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
  localparam logic [1:0] ST_RESP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ACCESS = ST_ACCESS_ENC,
    ST_RESP   = ST_RESP_ENC
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and size/alignment legality.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic              is_write,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] prdata,
  output logic [DATA_W-1:0] pwdata_c,
  output logic [STRB_W-1:0] pstrb_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              align_ok_c
);

  logic       legal_size;
  logic       aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    legal_size = 1'b0;
    aligned    = 1'b0;
    byte_sel   = prdata[7:0];
    half_sel   = addr_lo[1] ? prdata[31:16] : prdata[15:0];
    pwdata_c   = wdata;
    pstrb_c    = 4'b1111;
    rdata_c    = prdata;

    if (is_write) begin
      legal_size = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legal_size = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                   (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end

    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
    align_ok_c = legal_size & aligned;

    case (addr_lo)
      2'd0:    byte_sel = prdata[7:0];
      2'd1:    byte_sel = prdata[15:8];
      2'd2:    byte_sel = prdata[23:16];
      default: byte_sel = prdata[31:24];
    endcase

    // funct3[2] selects zero extension for LBU/LHU
    case (funct3[1:0])
      2'b00: begin
        pwdata_c = {4{wdata[7:0]}};
        pstrb_c  = 4'(4'b0001 << addr_lo);
        rdata_c  = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        pwdata_c = {2{wdata[15:0]}};
        pstrb_c  = 4'(4'b0011 << addr_lo);
        rdata_c  = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        pwdata_c = wdata;
        pstrb_c  = 4'b1111;
        rdata_c  = prdata;
      end
    endcase
  end

endmodule

// File: rtl/apb_lsu_master.sv
// Turns level-held load/store requests into single APB4 transfers with a one-cycle mem_ready pulse.
module apb_lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_funct3,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic [1:0]        mem_err_cause,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [STRB_W-1:0] pstrb,
  output logic [2:0]        pprot,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [1:0]        cause_q, cause_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic              req_c;
  logic              req_write_c;
  logic              lane_write;
  logic [2:0]        lane_funct3;
  logic [1:0]        lane_addr_lo;
  logic [DATA_W-1:0] lane_pwdata;
  logic [STRB_W-1:0] lane_pstrb;
  logic [DATA_W-1:0] lane_rdata;
  logic              lane_align_ok;
  logic [CNT_W-1:0]  cnt_inc;

  assign req_c       = mem_read_en | mem_write_en;
  assign req_write_c = mem_write_en & ~mem_read_en;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // In IDLE the lane logic sees the live request; afterwards it sees the captured access.
  assign lane_write   = (state_q == ST_IDLE) ? req_write_c       : pwrite_q;
  assign lane_funct3  = (state_q == ST_IDLE) ? mem_funct3        : funct3_q;
  assign lane_addr_lo = (state_q == ST_IDLE) ? mem_addr[1:0]     : addr_lo_q;

  lsu_lane_align u_lane_align (
    .is_write   (lane_write),
    .funct3     (lane_funct3),
    .addr_lo    (lane_addr_lo),
    .wdata      (mem_wdata),
    .prdata     (prdata),
    .pwdata_c   (lane_pwdata),
    .pstrb_c    (lane_pstrb),
    .rdata_c    (lane_rdata),
    .align_ok_c (lane_align_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      cause_q   <= ERR_NONE;
      rdata_q   <= '0;
      cnt_q     <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    cause_d   = cause_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          funct3_d  = mem_funct3;
          addr_lo_d = mem_addr[1:0];
          pwrite_d  = req_write_c;
          cnt_d     = '0;
          if (lane_align_ok) begin
            cause_d  = ERR_NONE;
            paddr_d  = ADDR_W'({mem_addr[31:2], 2'b00});
            pwdata_d = lane_pwdata;
            pstrb_d  = req_write_c ? lane_pstrb : '0;
            psel_d   = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            cause_d = ERR_ALIGN;
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) begin
            rdata_d = lane_rdata;
          end
          cause_d = pslverr ? ERR_SLV : ERR_NONE;
          err_d   = pslverr;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cnt_d     = cnt_inc;
          cause_d   = ERR_TIMEOUT;
          err_d     = 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_RESP;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign paddr         = paddr_q;
  assign psel          = psel_q;
  assign penable       = penable_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign pstrb         = pstrb_q;
  assign pprot         = 3'b000;
  assign mem_ready     = ready_q;
  assign mem_err       = err_q;
  assign mem_err_cause = cause_q;
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_apb_lsu_master.sv
// Directed checks of apb_lsu_master: lane steering, extension, latency, errors, timeout and reset.
module tb_apb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_ready, mem_err;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_err_cause;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  int n_checks = 0;
  int n_errors = 0;

  int          res_psel, res_pen, res_ready;
  bit          res_stable;
  logic [31:0] res_paddr, res_pwdata, res_rdata;
  logic [3:0]  res_pstrb;
  logic        res_pwrite, res_err, res_psel_rdy, res_ready_after;
  logic [1:0]  res_cause, res_cause_after;

  always #5 clk = ~clk;

  apb_lsu_master #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .mem_err_cause(mem_err_cause),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launches one request at cycle 0 and plays an APB slave with 'waits' low-pready cycles.
  task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input int waits,
                          input logic slverr, input logic [31:0] rdat);
    int  acc;
    bit  have;
    mem_read_en = rd; mem_write_en = wr; mem_addr = addr; mem_wdata = wdata; mem_funct3 = f3;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    res_psel = -1; res_pen = -1; res_ready = -1; res_stable = 1'b1; have = 1'b0; acc = 0;
    res_paddr = 32'h0; res_pwdata = 32'h0; res_pstrb = 4'h0; res_pwrite = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        mem_addr = ~addr; mem_wdata = ~wdata; mem_funct3 = ~f3;
      end
      if (psel && res_psel < 0) res_psel = cyc;
      if (penable && res_pen < 0) res_pen = cyc;
      if (psel) begin
        if (!have) begin
          have = 1'b1;
          res_paddr = paddr; res_pwdata = pwdata; res_pstrb = pstrb; res_pwrite = pwrite;
        end else if (paddr !== res_paddr || pwdata !== res_pwdata ||
                     pstrb !== res_pstrb || pwrite !== res_pwrite) begin
          res_stable = 1'b0;
        end
      end
      if (mem_ready) begin
        res_ready = cyc;
        break;
      end
      if (psel && penable) begin
        if (acc >= waits) begin
          pready = 1'b1; pslverr = slverr; prdata = rdat;
        end else begin
          pready = 1'b0;
        end
        acc++;
      end else begin
        pready = 1'b0;
      end
    end
    if (res_ready < 0) check("ready_wait", 32'h0, 32'h1);
    res_err = mem_err; res_cause = mem_err_cause; res_rdata = mem_rdata; res_psel_rdy = psel;
    pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    res_ready_after = mem_ready; res_cause_after = mem_err_cause;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_funct3 = 3'b000; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    check("rst_cause", 32'(mem_err_cause), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb", 32'(pstrb), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("pprot", 32'(pprot), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_xfer(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 0, 1'b0, 32'h0);
    check("sw_psel_cyc", 32'(res_psel), 32'd1);
    check("sw_pen_cyc", 32'(res_pen), 32'd2);
    check("sw_ready_cyc", 32'(res_ready), 32'd3);
    check("sw_paddr", res_paddr, 32'h0000_1000);
    check("sw_pwrite", 32'(res_pwrite), 32'h1);
    check("sw_pstrb", 32'(res_pstrb), 32'hF);
    check("sw_pwdata", res_pwdata, 32'hDEAD_BEEF);
    check("sw_err", 32'(res_err), 32'h0);
    check("sw_cause", 32'(res_cause), 32'h0);
    check("sw_ready_pulse", 32'(res_ready_after), 32'h0);

    run_xfer(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'b000, 0, 1'b0, 32'h8A12_3456);
    check("lb_paddr", res_paddr, 32'h0000_2000);
    check("lb_pwrite", 32'(res_pwrite), 32'h0);
    check("lb_pstrb", 32'(res_pstrb), 32'h0);
    check("lb_rdata", res_rdata, 32'hFFFF_FF8A);
    check("lb_ready_cyc", 32'(res_ready), 32'd3);

    run_xfer(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'b100, 0, 1'b0, 32'h8A12_3456);
    check("lbu_rdata", res_rdata, 32'h0000_008A);

    run_xfer(1'b0, 1'b1, 32'h0000_1002, 32'h0000_ABCD, 3'b001, 3, 1'b0, 32'h0);
    check("sh_pstrb", 32'(res_pstrb), 32'hC);
    check("sh_pwdata", res_pwdata, 32'hABCD_ABCD);
    check("sh_stable", 32'(res_stable), 32'h1);
    check("sh_ready_cyc", 32'(res_ready), 32'd6);
    check("sh_rdata_kept", res_rdata, 32'h0000_008A);

    run_xfer(1'b1, 1'b0, 32'h0000_1001, 32'h0, 3'b010, 0, 1'b0, 32'h0);
    check("lw_mis_psel", 32'(res_psel), 32'hFFFF_FFFF);
    check("lw_mis_ready_cyc", 32'(res_ready), 32'd1);
    check("lw_mis_err", 32'(res_err), 32'h1);
    check("lw_mis_cause", 32'(res_cause), 32'h1);
    check("lw_mis_cause_hold", 32'(res_cause_after), 32'h1);
    check("lw_mis_ready_pulse", 32'(res_ready_after), 32'h0);

    run_xfer(1'b1, 1'b0, 32'h0000_1003, 32'h0, 3'b001, 0, 1'b0, 32'h0);
    check("lh_mis_psel", 32'(res_psel), 32'hFFFF_FFFF);
    check("lh_mis_ready_cyc", 32'(res_ready), 32'd1);
    check("lh_mis_cause", 32'(res_cause), 32'h1);

    run_xfer(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 3'b100, 0, 1'b0, 32'h0);
    check("st_ill_psel", 32'(res_psel), 32'hFFFF_FFFF);
    check("st_ill_cause", 32'(res_cause), 32'h1);

    run_xfer(1'b0, 1'b1, 32'h0000_4001, 32'h0000_00A5, 3'b000, 0, 1'b1, 32'h0);
    check("sb_pstrb", 32'(res_pstrb), 32'h2);
    check("sb_pwdata", res_pwdata, 32'hA5A5_A5A5);
    check("slv_err", 32'(res_err), 32'h1);
    check("slv_cause", 32'(res_cause), 32'h2);

    run_xfer(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'b010, 100, 1'b0, 32'h0);
    check("to_ready_cyc", 32'(res_ready), 32'd10);
    check("to_cause", 32'(res_cause), 32'h3);
    check("to_err", 32'(res_err), 32'h1);
    check("to_psel_resp", 32'(res_psel_rdy), 32'h0);

    run_xfer(1'b1, 1'b0, 32'h0000_6002, 32'h0, 3'b001, 0, 1'b0, 32'h8001_7FFF);
    check("lh_rdata", res_rdata, 32'hFFFF_8001);
    check("lh_cause_clear", 32'(res_cause), 32'h0);
    run_xfer(1'b1, 1'b0, 32'h0000_6000, 32'h0, 3'b101, 1, 1'b0, 32'h8001_7FFF);
    check("lhu_rdata", res_rdata, 32'h0000_7FFF);
    check("lhu_ready_cyc", 32'(res_ready), 32'd4);

    run_xfer(1'b1, 1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 3'b010, 0, 1'b0, 32'h5555_AAAA);
    check("both_pwrite", 32'(res_pwrite), 32'h0);
    check("both_pstrb", 32'(res_pstrb), 32'h0);
    check("both_rdata", res_rdata, 32'h5555_AAAA);

    // Reset while the slave holds the bus in ACCESS
    mem_read_en = 1'b1; mem_addr = 32'h0000_3000; mem_funct3 = 3'b010; pready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_in_access", 32'(penable), 32'h1);
    rst = 1'b1; mem_read_en = 1'b0;
    @(posedge clk); #1;
    check("rstmid_psel", 32'(psel), 32'h0);
    check("rstmid_penable", 32'(penable), 32'h0);
    check("rstmid_ready", 32'(mem_ready), 32'h0);
    check("rstmid_cause", 32'(mem_err_cause), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_xfer(1'b1, 1'b0, 32'h0000_7000, 32'h0, 3'b010, 0, 1'b0, 32'h1122_3344);
    check("post_rst_ready_cyc", 32'(res_ready), 32'd3);
    check("post_rst_rdata", res_rdata, 32'h1122_3344);
    check("post_rst_err", 32'(res_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_lsu_master.md
Name: apb_lsu_master

Overview:
- Load/store unit sitting directly downstream of the multicycle control FSM.
- Converts level-held mem_read_en / mem_write_en requests into single APB4 transfers, and returns mem_ready as a one-cycle pulse.
- Store side: byte-lane steering and strobes. Load side: lane extraction with sign/zero extension.
- Detects misalignment and bus errors, and bounds slave wait states with a timeout counter.

Parameters:
- ADDR_W, 32, APB address width.
- TIMEOUT_CYCLES, 256, max ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- mem_read_en, input, 1, load request; held high by the FSM until mem_ready.
- mem_write_en, input, 1, store request; held high until mem_ready.
- mem_addr, input, 32, byte address (ALU output register).
- mem_wdata, input, 32, store data (rs2, right-justified).
- mem_funct3, input, 3, access size/sign (instr[14:12]).
- mem_ready, output, 1, one-cycle completion pulse.
- mem_rdata, output, 32, extended load data; valid from the mem_ready cycle, held until the next load completes.
- mem_err, output, 1, high with mem_ready if the access failed.
- mem_err_cause, output, 2, 00 none, 01 misaligned/illegal size, 10 pslverr, 11 timeout; held until the next request is accepted.
- paddr, output, ADDR_W, word-aligned address {addr[31:2],2'b00}.
- psel, output, 1, APB select.
- penable, output, 1, APB enable.
- pwrite, output, 1, APB direction.
- pwdata, output, 32, lane-replicated write data.
- pstrb, output, 4, write strobes; 0000 for reads.
- pprot, output, 3, constant 3'b000.
- prdata, input, 32, APB read data.
- pready, input, 1, APB ready.
- pslverr, input, 1, APB error.

Behaviour:
- Reset (synchronous, rst high at posedge): state IDLE; psel, penable, pwrite, mem_ready, mem_err = 0; paddr, pwdata, pstrb, mem_rdata = 0; mem_err_cause = 00; timeout counter = 0.
- rst mid-transfer: psel and penable drop at that edge; the slave transfer is abandoned with no response.

State machine (IDLE, SETUP, ACCESS, RESP):
- IDLE:
  - On mem_read_en or mem_write_en: capture addr, wdata, funct3 and direction. Read wins if both are asserted.
  - Alignment/size check on captured values:
    - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
    - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Fail: go to RESP with cause 01. No APB activity.
  - Pass: go to SETUP and drive paddr, pwrite, pwdata, pstrb.
- SETUP: psel=1, penable=0. Go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. Counter increments each cycle pready is low.
  - pready=1: latch extended prdata (loads only). Cause 10 if pslverr, else 00. Go to RESP.
  - Counter reaches TIMEOUT_CYCLES (nonzero): cause 11, go to RESP. psel/penable drop at that edge.
- RESP: mem_ready=1 for exactly one cycle; mem_err = (cause != 00). Then IDLE.
  - The FSM drops its request the cycle after mem_ready, so IDLE never re-launches the same access.

Latency and stability:
- Zero-wait latency: request seen in IDLE cycle 0; SETUP 1; ACCESS 2; mem_ready cycle 3.
- Each pready-low cycle adds 1.
- Misaligned: mem_ready at cycle 1.
- APB outputs are registered and stable from SETUP through the ACCESS completion edge, independent of input changes.

Store lane rules (addr[1:0] = a):
- SB: pwdata = {4{wdata[7:0]}}, pstrb = 0001 << a.
- SH: pwdata = {2{wdata[15:0]}}, pstrb = 0011 << a.
- SW: pwdata = wdata, pstrb = 1111.

Load extraction:
- Byte = prdata[8a+7:8a]; LB sign-extends, LBU zero-extends.
- Half = prdata[16a[1]+15:16a[1]]; LH sign-extends, LHU zero-extends.
- LW = prdata.
- Stores leave mem_rdata unchanged.

Decomposition:
- Package lsu_pkg:
  - funct3 size constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - Error-cause constants (ERR_NONE, ERR_ALIGN, ERR_SLV, ERR_TIMEOUT).
  - State encoding localparams.
- One combinational sub-module, lsu_lane_align:
  - Inputs: funct3, addr[1:0], wdata, prdata.
  - Outputs: pwdata, pstrb, extended rdata, align_ok.
- Top holds the FSM, capture registers and timeout counter.

Test Plan:
- SW 0xDEADBEEF @0x0000_1000, pready=1 in first ACCESS -> psel cycle 1, penable cycle 2, pstrb 1111, pwdata DEADBEEF, mem_ready cycle 3, mem_err 0.
- LB @0x2003, prdata 0x8A123456 -> paddr 0x2000, pstrb 0000, mem_rdata 0xFFFFFF8A; repeat as LBU -> 0x0000008A.
- SH wdata 0x0000ABCD @0x1002, pready low 3 cycles -> pstrb 1100, pwdata ABCDABCD, APB signals stable, mem_ready cycle 6.
- LW @0x1001 and LH @0x1003 -> psel never asserted, mem_ready cycle 1, mem_err 1, cause 01.
- Store with pslverr=1 on pready -> cause 10. TIMEOUT_CYCLES=8 with pready stuck low -> abort after 8 ACCESS cycles, cause 11, psel 0 in RESP.
- rst asserted during ACCESS -> next cycle psel=penable=mem_ready=0, cause 00; a following LW completes normally.
